// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, shared-ALU and response bundle for alu_arbiter
interface alu_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic [3:0]       req0_op;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic [3:0]       req1_op;
    logic [TAG_W-1:0] req1_tag;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_op;
    logic [31:0]      alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;

    // slave: the arbiter; master: requesters, shared ALU and response consumer
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_op, req1_tag,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_tag,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_tag,
        output req1_valid, req1_a, req1_b, req1_op, req1_tag,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_tag,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one combinational ALU with a registered response stage
module alu_arbiter #(
    parameter int TAG_W      = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    logic             last_grant;
    logic             gnt_vld;
    logic             gnt;
    logic             can_accept;
    logic             accept;

    logic             rsp_valid_q;
    logic [31:0]      rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_id_q;
    logic [TAG_W-1:0] rsp_tag_q;

    always_comb begin
        gnt_vld = bus.req0_valid | bus.req1_valid;
        gnt     = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else begin
            gnt = bus.req1_valid;
        end
    end

    // Response slot frees up in the same cycle it drains, so no bubble on sustained traffic
    assign can_accept = ~rsp_valid_q | bus.rsp_ready;
    assign accept     = rst_n & gnt_vld & can_accept;

    assign bus.req0_ready = accept & ~gnt;
    assign bus.req1_ready = accept &  gnt;

    // ALU mux follows the grant alone so the result is ready the moment backpressure lifts
    always_comb begin
        bus.alu_a  = 32'd0;
        bus.alu_b  = 32'd0;
        bus.alu_op = 4'b0000;
        if (gnt_vld) begin
            if (gnt) begin
                bus.alu_a  = bus.req1_a;
                bus.alu_b  = bus.req1_b;
                bus.alu_op = bus.req1_op;
            end else begin
                bus.alu_a  = bus.req0_a;
                bus.alu_b  = bus.req0_b;
                bus.alu_op = bus.req0_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant   <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
        end else if (accept) begin
            last_grant   <= gnt;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= bus.alu_result;
            rsp_zero_q   <= bus.alu_zero;
            rsp_id_q     <= gnt;
            rsp_tag_q    <= gnt ? bus.req1_tag : bus.req0_tag;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_tag    = rsp_tag_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter, round-robin and fixed-priority instances
module tb_alu_arbiter;
    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        id;
        logic [3:0]  tag;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]  v0, v1, rr;
    logic [31:0] a0 [2];
    logic [31:0] b0 [2];
    logic [31:0] a1 [2];
    logic [31:0] b1 [2];
    logic [3:0]  op0 [2];
    logic [3:0]  op1 [2];
    logic [3:0]  t0 [2];
    logic [3:0]  t1 [2];

    int n_total, n_pass;

    logic m_last [2];
    logic m_rv   [2];
    rsp_t m_cur  [2];
    rsp_t sb0 [$];
    rsp_t sb1 [$];

    alu_arbiter_if #(.TAG_W(4)) if_rr ();
    alu_arbiter_if #(.TAG_W(4)) if_fp ();

    alu_arbiter #(.TAG_W(4), .FIXED_PRIO(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr.slave));
    alu_arbiter #(.TAG_W(4), .FIXED_PRIO(1)) u_fp (.clk(clk), .rst_n(rst_n), .bus(if_fp.slave));

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return {31'd0, $signed(a) < $signed(b)};
            4'd9:    return {31'd0, a < b};
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    assign if_rr.req0_valid = v0[0];  assign if_fp.req0_valid = v0[1];
    assign if_rr.req1_valid = v1[0];  assign if_fp.req1_valid = v1[1];
    assign if_rr.req0_a = a0[0];      assign if_fp.req0_a = a0[1];
    assign if_rr.req0_b = b0[0];      assign if_fp.req0_b = b0[1];
    assign if_rr.req0_op = op0[0];    assign if_fp.req0_op = op0[1];
    assign if_rr.req0_tag = t0[0];    assign if_fp.req0_tag = t0[1];
    assign if_rr.req1_a = a1[0];      assign if_fp.req1_a = a1[1];
    assign if_rr.req1_b = b1[0];      assign if_fp.req1_b = b1[1];
    assign if_rr.req1_op = op1[0];    assign if_fp.req1_op = op1[1];
    assign if_rr.req1_tag = t1[0];    assign if_fp.req1_tag = t1[1];
    assign if_rr.rsp_ready = rr[0];   assign if_fp.rsp_ready = rr[1];
    assign if_rr.alu_result = alu_ref(if_rr.alu_a, if_rr.alu_b, if_rr.alu_op);
    assign if_rr.alu_zero   = (alu_ref(if_rr.alu_a, if_rr.alu_b, if_rr.alu_op) == 32'd0);
    assign if_fp.alu_result = alu_ref(if_fp.alu_a, if_fp.alu_b, if_fp.alu_op);
    assign if_fp.alu_zero   = (alu_ref(if_fp.alu_a, if_fp.alu_b, if_fp.alu_op) == 32'd0);

    function automatic logic [1:0] get_rdy(input int s);
        return (s == 1) ? {if_fp.req1_ready, if_fp.req0_ready} : {if_rr.req1_ready, if_rr.req0_ready};
    endfunction

    function automatic logic get_rv(input int s);
        return (s == 1) ? if_fp.rsp_valid : if_rr.rsp_valid;
    endfunction

    function automatic rsp_t get_rsp(input int s);
        rsp_t r;
        if (s == 1) r = {if_fp.rsp_result, if_fp.rsp_zero, if_fp.rsp_id, if_fp.rsp_tag};
        else        r = {if_rr.rsp_result, if_rr.rsp_zero, if_rr.rsp_id, if_rr.rsp_tag};
        return r;
    endfunction

    function automatic logic [67:0] get_alu(input int s);
        return (s == 1) ? {if_fp.alu_a, if_fp.alu_b, if_fp.alu_op} : {if_rr.alu_a, if_rr.alu_b, if_rr.alu_op};
    endfunction

    task automatic rand_port(input int s, input int p);
        if (p == 0) begin
            a0[s] = $urandom; b0[s] = $urandom; op0[s] = 4'($urandom_range(0, 11)); t0[s] = 4'($urandom);
        end else begin
            a1[s] = $urandom; b1[s] = $urandom; op1[s] = 4'($urandom_range(0, 11)); t1[s] = 4'($urandom);
        end
    endtask

    // One clock of instance s: check handshake/ALU drive against the model, push, then check the response
    task automatic cyc(input int s, output int acc);
        logic g_vld, g, can;
        logic [1:0]  er, dr;
        logic [67:0] ealu, dalu;
        rsp_t e, got;
        #1;
        g_vld = v0[s] | v1[s];
        if (v0[s] && v1[s]) g = (s == 1) ? 1'b0 : ~m_last[s];
        else                g = v1[s];
        can = !m_rv[s] || rr[s];
        er  = {g_vld && g && can, g_vld && !g && can};
        dr  = get_rdy(s);
        n_total++;
        if (dr !== er) $display("FAIL ready inst%0d: got %b expected %b", s, dr, er);
        else n_pass++;
        if (!g_vld)  ealu = 68'd0;
        else if (g)  ealu = {a1[s], b1[s], op1[s]};
        else         ealu = {a0[s], b0[s], op0[s]};
        dalu = get_alu(s);
        n_total++;
        if (dalu !== ealu) $display("FAIL alu_drive inst%0d: got %h expected %h", s, dalu, ealu);
        else n_pass++;
        acc = -1;
        if (g_vld && can) begin
            e.r   = g ? alu_ref(a1[s], b1[s], op1[s]) : alu_ref(a0[s], b0[s], op0[s]);
            e.z   = (e.r == 32'd0);
            e.id  = g;
            e.tag = g ? t1[s] : t0[s];
            if (s == 1) sb1.push_back(e); else sb0.push_back(e);
            m_last[s] = g;
            m_rv[s]   = 1'b1;
            acc       = g ? 1 : 0;
        end else if (m_rv[s] && rr[s]) begin
            m_rv[s] = 1'b0;
        end
        @(negedge clk);
        if (acc >= 0) begin
            n_total++;
            if ((s == 1 ? sb1.size() : sb0.size()) == 0) $display("FAIL scoreboard_empty inst%0d", s);
            else begin
                n_pass++;
                m_cur[s] = (s == 1) ? sb1.pop_front() : sb0.pop_front();
            end
        end
        n_total++;
        if (get_rv(s) !== m_rv[s]) $display("FAIL rsp_valid inst%0d: got %b expected %b", s, get_rv(s), m_rv[s]);
        else n_pass++;
        got = get_rsp(s);
        n_total++;
        if (got !== m_cur[s]) $display("FAIL rsp_fields inst%0d: got %h expected %h", s, got, m_cur[s]);
        else n_pass++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            v0[s] = 1'b1; v1[s] = 1'b1; rr[s] = 1'b0;
            rand_port(s, 0); rand_port(s, 1);
        end
        #1;
        for (int s = 0; s < 2; s++) begin
            n_total++;
            if (get_rdy(s) !== 2'b00) $display("FAIL reset_ready inst%0d: got %b expected 00", s, get_rdy(s));
            else n_pass++;
        end
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_total++;
            if ({get_rv(s), get_rsp(s)} !== 39'd0)
                $display("FAIL reset_rsp inst%0d: got %h expected 0", s, {get_rv(s), get_rsp(s)});
            else n_pass++;
            m_last[s] = 1'b1; m_rv[s] = 1'b0; m_cur[s] = '0;
            v0[s] = 1'b0; v1[s] = 1'b0;
        end
        sb0.delete(); sb1.delete();
        rst_n = 1'b1;
    endtask

    task automatic run_both(input int s, input int n, input logic [3:0] exp_ids);
        int acc;
        v0[s] = 1'b1; v1[s] = 1'b1; rr[s] = 1'b1;
        rand_port(s, 0); rand_port(s, 1);
        for (int i = 0; i < n; i++) begin
            cyc(s, acc);
            n_total++;
            if (acc !== int'(exp_ids[i])) $display("FAIL grant_seq inst%0d step%0d: got %0d expected %0d", s, i, acc, exp_ids[i]);
            else n_pass++;
            if (acc >= 0) rand_port(s, acc);
        end
        v0[s] = 1'b0; v1[s] = 1'b0;
        cyc(s, acc);
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single_port0();
        int acc;
        rr[0] = 1'b1; v0[0] = 1'b1;
        a0[0] = 32'h5; b0[0] = 32'h7; op0[0] = 4'd0; t0[0] = 4'd3;
        cyc(0, acc);
        v0[0] = 1'b0;
        n_total++;
        if ({get_rv(0), get_rsp(0)} !== {1'b1, 32'hC, 1'b0, 1'b0, 4'd3})
            $display("FAIL add_p0: got %h expected %h", {get_rv(0), get_rsp(0)}, {1'b1, 32'hC, 1'b0, 1'b0, 4'd3});
        else n_pass++;
        cyc(0, acc);
    endtask

    task automatic test_port1();
        int acc;
        rr[0] = 1'b1; v1[0] = 1'b1;
        a1[0] = 32'h3; b1[0] = 32'h3; op1[0] = 4'd1; t1[0] = 4'd5;
        cyc(0, acc);
        n_total++;
        if (get_rsp(0) !== {32'h0, 1'b1, 1'b1, 4'd5}) $display("FAIL sub_p1: got %h expected %h", get_rsp(0), {32'h0, 1'b1, 1'b1, 4'd5});
        else n_pass++;
        a1[0] = 32'h8000_0000; b1[0] = 32'd4; op1[0] = 4'd7; t1[0] = 4'd6;
        cyc(0, acc);
        n_total++;
        if (get_rsp(0).r !== 32'hF800_0000) $display("FAIL sra_p1: got %h expected F8000000", get_rsp(0).r);
        else n_pass++;
        v1[0] = 1'b0;
        cyc(0, acc);
    endtask

    task automatic test_round_robin();
        do_reset();
        run_both(0, 4, 4'b1010);
    endtask

    task automatic test_fixed_prio();
        do_reset();
        run_both(1, 4, 4'b0000);
    endtask

    task automatic test_backpressure();
        int acc;
        do_reset();
        v0[0] = 1'b1; v1[0] = 1'b1; rr[0] = 1'b1;
        rand_port(0, 0); rand_port(0, 1);
        cyc(0, acc);
        if (acc >= 0) rand_port(0, acc);
        rr[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, acc);
            n_total++;
            if (acc !== -1) $display("FAIL stall_accept step%0d: got %0d expected -1", i, acc);
            else n_pass++;
        end
        rr[0] = 1'b1;
        cyc(0, acc);
        n_total++;
        if (acc !== 1) $display("FAIL release_grant: got %0d expected 1", acc);
        else n_pass++;
        v0[0] = 1'b0; v1[0] = 1'b0;
        cyc(0, acc);
    endtask

    task automatic test_back_to_back();
        int acc;
        rr[0] = 1'b1; v0[0] = 1'b1;
        a0[0] = 32'hFFFF_FFFF; b0[0] = 32'd1; op0[0] = 4'd8; t0[0] = 4'd1;
        cyc(0, acc);
        n_total++;
        if ({get_rv(0), get_rsp(0).r} !== {1'b1, 32'h1}) $display("FAIL slt: got %h expected 100000001", {get_rv(0), get_rsp(0).r});
        else n_pass++;
        op0[0] = 4'd9; t0[0] = 4'd2;
        cyc(0, acc);
        n_total++;
        if ({get_rv(0), get_rsp(0).r} !== {1'b1, 32'h0}) $display("FAIL sltu: got %h expected 100000000", {get_rv(0), get_rsp(0).r});
        else n_pass++;
        v0[0] = 1'b0;
        cyc(0, acc);
    endtask

    task automatic test_reset_midflight();
        int acc;
        rr[0] = 1'b0; v0[0] = 1'b1;
        a0[0] = 32'h1; b0[0] = 32'h2; op0[0] = 4'd0; t0[0] = 4'd4;
        cyc(0, acc);
        v0[0] = 1'b0;
        do_reset();
        v0[0] = 1'b1; v1[0] = 1'b1; rr[0] = 1'b1;
        rand_port(0, 0); rand_port(0, 1);
        cyc(0, acc);
        n_total++;
        if (acc !== 0) $display("FAIL post_reset_grant: got %0d expected 0", acc);
        else n_pass++;
        v0[0] = 1'b0; v1[0] = 1'b0;
        cyc(0, acc);
    endtask

    initial begin
        n_total = 0; n_pass = 0;
        rst_n = 1'b1; v0 = '0; v1 = '0; rr = '0;
        for (int s = 0; s < 2; s++) begin
            a0[s] = '0; b0[s] = '0; op0[s] = '0; t0[s] = '0;
            a1[s] = '0; b1[s] = '0; op1[s] = '0; t1[s] = '0;
        end
        @(negedge clk);
        test_reset();
        test_single_port0();
        test_port1();
        test_round_robin();
        test_fixed_prio();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
